mem_write_arbiter: RTL and testbench

//   Shares one protected memory write port between N_REQ requesting modules.
//   - Round-robin arbitration among requesters.
//   - Each request is checked against a per-region permission table.
//   - Permitted writes go downstream over a valid/ready port.
//   - Denied writes are dropped and logged. Repeat offenders are locked out.

---
 rtl/mem_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_write_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter that shares one protected memory write port between N_REQ requesters.
// Writes are checked against a per-region permission table; repeat offenders get locked out.
module mem_write_arbiter #(
  parameter int                 N_REQ       = 4,
  parameter int                 AW          = 4,
  parameter int                 DW          = 4,
  parameter int                 LOCK_THRESH = 3,
  parameter logic [4*N_REQ-1:0] PERM_RST    = 16'h423F
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      deny,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [DW-1:0]         mem_wr_data,
  output logic [$clog2(N_REQ)-1:0] mem_wr_id,
  input  logic                  cfg_we,
  input  logic [4*N_REQ-1:0]    cfg_perm,
  input  logic                  lock_clr,
  output logic                  violation,
  output logic [AW-1:0]         viol_addr,
  output logic [$clog2(N_REQ)-1:0] viol_id,
  output logic [7:0]            viol_count,
  output logic [N_REQ-1:0]      locked
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_THRESH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DENY} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_rr;
  logic [4*N_REQ-1:0]  r_perm;
  logic [CW-1:0]       r_cnt [N_REQ];
  logic [N_REQ-1:0]    r_locked;
  logic [IW-1:0]       r_id;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_data;
  logic [AW-1:0]       r_viol_addr;
  logic [IW-1:0]       r_viol_id;
  logic [7:0]          r_viol_count;

  logic [N_REQ-1:0]    w_elig;
  logic                w_found;
  logic [IW-1:0]       w_pick;
  logic [AW-1:0]       w_pick_addr;
  logic [DW-1:0]       w_pick_data;
  logic [1:0]          w_region;
  logic                w_perm_ok;

  function automatic logic [IW-1:0] nextId(input logic [IW-1:0] id);
    if (int'(id) == N_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  assign w_elig = req & ~r_locked;

  // First eligible requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[(int'(r_rr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_rr) + k) % N_REQ);
      end
    end
  end

  assign w_pick_addr = req_addr[int'(w_pick)*AW +: AW];
  assign w_pick_data = req_data[int'(w_pick)*DW +: DW];
  assign w_region    = w_pick_addr[AW-1:AW-2];
  assign w_perm_ok   = r_perm[int'(w_region)*N_REQ + int'(w_pick)];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_rr         <= '0;
      r_perm       <= PERM_RST;
      r_locked     <= '0;
      r_id         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_viol_addr  <= '0;
      r_viol_id    <= '0;
      r_viol_count <= '0;
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      if (cfg_we) r_perm <= cfg_perm;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_id   <= w_pick;
            r_addr <= w_pick_addr;
            r_data <= w_pick_data;
            if (w_perm_ok) begin
              r_state <= ISSUE;
            end else begin
              // Denial bookkeeping is done on entry so it is visible during the DENY cycle.
              r_state     <= DENY;
              r_viol_addr <= w_pick_addr;
              r_viol_id   <= w_pick;
              if (r_viol_count != 8'hFF) r_viol_count <= r_viol_count + 8'd1;
              r_cnt[w_pick] <= r_cnt[w_pick] + 1'b1;
              if (r_cnt[w_pick] == CW'(LOCK_THRESH - 1)) r_locked[w_pick] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_wr_ready) begin
            r_rr    <= nextId(r_id);
            r_state <= IDLE;
          end
        end
        DENY: begin
          r_rr    <= nextId(r_id);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Placed last so a clear beats a coinciding denial.
      if (lock_clr) begin
        r_locked <= '0;
        for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
      end
    end
  end

  assign mem_wr_valid = (r_state == ISSUE);
  assign violation    = (r_state == DENY);
  assign gnt          = (r_state == ISSUE && mem_wr_ready) ? (N_REQ'(1) << r_id) : '0;
  assign deny         = (r_state == DENY) ? (N_REQ'(1) << r_id) : '0;
  assign mem_wr_addr  = r_addr;
  assign mem_wr_data  = r_data;
  assign mem_wr_id    = r_id;
  assign viol_addr    = r_viol_addr;
  assign viol_id      = r_viol_id;
  assign viol_count   = r_viol_count;
  assign locked       = r_locked;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: a vector table for single transactions plus
// hand-written sequences for round-robin order, backpressure, lockout, config and reset.
module tb_mem_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] reqAddr;
  logic [15:0] reqData;
  logic [3:0]  gnt;
  logic [3:0]  deny;
  logic        memWrValid;
  logic        memWrReady;
  logic [3:0]  memWrAddr;
  logic [3:0]  memWrData;
  logic [1:0]  memWrId;
  logic        cfgWe;
  logic [15:0] cfgPerm;
  logic        lockClr;
  logic        violation;
  logic [3:0]  violAddr;
  logic [1:0]  violId;
  logic [7:0]  violCount;
  logic [3:0]  locked;

  int compared   = 0;
  int mismatched = 0;

  mem_write_arbiter dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req         (req),
    .req_addr    (reqAddr),
    .req_data    (reqData),
    .gnt         (gnt),
    .deny        (deny),
    .mem_wr_valid(memWrValid),
    .mem_wr_ready(memWrReady),
    .mem_wr_addr (memWrAddr),
    .mem_wr_data (memWrData),
    .mem_wr_id   (memWrId),
    .cfg_we      (cfgWe),
    .cfg_perm    (cfgPerm),
    .lock_clr    (lockClr),
    .violation   (violation),
    .viol_addr   (violAddr),
    .viol_id     (violId),
    .viol_count  (violCount),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [15:0] addr;
    logic [15:0] data;
    logic        expValid;
    logic [3:0]  expGnt;
    logic [3:0]  expDeny;
    logic [3:0]  expAddr;
    logic [3:0]  expData;
    logic [1:0]  expId;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Outputs are sampled 1 ns after the active edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] a, input logic [15:0] d);
    req     = r;
    reqAddr = a;
    reqData = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'h0, 16'h0, 16'h0);
    memWrReady = 1'b1;
    cfgWe = 1'b0;
    cfgPerm = 16'h0;
    lockClr = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  // Denies one ID3 write to region 2 and returns to IDLE.
  task automatic denyId3(input string name);
    applyStimulus(4'b1000, 16'hA000, 16'h5000);
    stepCycle();
    checkOutput(name, deny, 4'b1000);
    req = 4'h0;
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int order[3];
    vecs[0] = '{"t1_id2_deny",   4'b0100, 16'h0900, 16'h0F00, 1'b0, 4'b0000, 4'b0100, 4'h9, 4'h0, 2'd2};
    vecs[1] = '{"t2_id1_grant",  4'b0010, 16'h00A0, 16'h00A0, 1'b1, 4'b0010, 4'b0000, 4'hA, 4'hA, 2'd1};
    vecs[2] = '{"t3_id3_deny",   4'b1000, 16'hA000, 16'h5000, 1'b0, 4'b0000, 4'b1000, 4'hA, 4'h0, 2'd3};
    vecs[3] = '{"t3_id2_grant",  4'b0100, 16'h0C00, 16'h0C00, 1'b1, 4'b0100, 4'b0000, 4'hC, 4'hC, 2'd2};
    vecs[4] = '{"all_reg0",      4'b1111, 16'h3210, 16'h7654, 1'b1, 4'b0001, 4'b0000, 4'h0, 4'h4, 2'd0};
    vecs[5] = '{"id0_reg1",      4'b0001, 16'h0005, 16'h0006, 1'b1, 4'b0001, 4'b0000, 4'h5, 4'h6, 2'd0};
    vecs[6] = '{"id2_reg1_deny", 4'b0100, 16'h0500, 16'h0100, 1'b0, 4'b0000, 4'b0100, 4'h5, 4'h0, 2'd2};
    vecs[7] = '{"id1_reg2",      4'b0010, 16'h0080, 16'h0030, 1'b1, 4'b0010, 4'b0000, 4'h8, 4'h3, 2'd1};
    vecs[8] = '{"id0_reg3_deny", 4'b0001, 16'h000F, 16'h0002, 1'b0, 4'b0000, 4'b0001, 4'hF, 4'h0, 2'd0};
    vecs[9] = '{"no_req",        4'b0000, 16'h1234, 16'h5678, 1'b0, 4'b0000, 4'b0000, 4'h0, 4'h0, 2'd0};

    doReset();
    checkOutput("rst_valid", memWrValid, 1'b0);
    checkOutput("rst_gnt", gnt, 4'h0);
    checkOutput("rst_deny", deny, 4'h0);
    checkOutput("rst_violation", violation, 1'b0);
    checkOutput("rst_viol_count", violCount, 8'h0);
    checkOutput("rst_viol_addr", violAddr, 4'h0);
    checkOutput("rst_viol_id", violId, 2'h0);
    checkOutput("rst_locked", locked, 4'h0);
    checkOutput("rst_wr_addr", memWrAddr, 4'h0);
    checkOutput("rst_wr_data", memWrData, 4'h0);
    checkOutput("rst_wr_id", memWrId, 2'h0);

    for (int v = 0; v < 10; v++) begin
      doReset();
      applyStimulus(vecs[v].req, vecs[v].addr, vecs[v].data);
      stepCycle();
      checkOutput({vecs[v].name, "_valid"}, memWrValid, vecs[v].expValid);
      checkOutput({vecs[v].name, "_gnt"}, gnt, vecs[v].expGnt);
      checkOutput({vecs[v].name, "_deny"}, deny, vecs[v].expDeny);
      checkOutput({vecs[v].name, "_violation"}, violation, |vecs[v].expDeny);
      if (vecs[v].expValid) begin
        checkOutput({vecs[v].name, "_addr"}, memWrAddr, vecs[v].expAddr);
        checkOutput({vecs[v].name, "_data"}, memWrData, vecs[v].expData);
        checkOutput({vecs[v].name, "_id"}, memWrId, vecs[v].expId);
      end
      if (|vecs[v].expDeny) begin
        checkOutput({vecs[v].name, "_viol_addr"}, violAddr, vecs[v].expAddr);
        checkOutput({vecs[v].name, "_viol_id"}, violId, vecs[v].expId);
        checkOutput({vecs[v].name, "_viol_count"}, violCount, 8'd1);
      end
      req = 4'h0;
      stepCycle();
      checkOutput({vecs[v].name, "_cycle2_valid"}, memWrValid, 1'b0);
      checkOutput({vecs[v].name, "_cycle2_deny"}, deny, 4'h0);
    end

    // Round-robin order with three simultaneous requesters, then ID3 ahead of ID0.
    doReset();
    applyStimulus(4'b0111, 16'h0210, 16'h0CBA);
    order = '{0, 1, 2};
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput($sformatf("t4_gnt_%0d", k), gnt, 4'b0001 << order[k]);
      checkOutput($sformatf("t4_id_%0d", k), memWrId, order[k]);
      req[order[k]] = 1'b0;
      stepCycle();
    end
    applyStimulus(4'b1001, 16'h0000, 16'h9000);
    stepCycle();
    checkOutput("t4_wrap_first", gnt, 4'b1000);
    req[3] = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("t4_wrap_second", gnt, 4'b0001);
    req = 4'h0;
    stepCycle();

    // Backpressure: everything held while ready is low, single grant once it rises.
    doReset();
    memWrReady = 1'b0;
    applyStimulus(4'b0010, 16'h00A0, 16'h00A0);
    stepCycle();
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("t5_hold_valid_%0d", c), memWrValid, 1'b1);
      checkOutput($sformatf("t5_hold_ad_%0d", c), {memWrAddr, memWrData, 2'b0, memWrId}, 12'hAA1);
      checkOutput($sformatf("t5_hold_gnt_%0d", c), gnt, 4'h0);
      stepCycle();
    end
    memWrReady = 1'b1;
    #1;
    checkOutput("t5_gnt", gnt, 4'b0010);
    req = 4'h0;
    stepCycle();
    checkOutput("t5_after_valid", memWrValid, 1'b0);
    checkOutput("t5_after_gnt", gnt, 4'h0);

    // A latched grant survives a permission change; later decisions use the new table.
    doReset();
    memWrReady = 1'b0;
    applyStimulus(4'b0010, 16'h00A0, 16'h00A0);
    stepCycle();
    cfgWe = 1'b1;
    cfgPerm = 16'h0000;
    stepCycle();
    cfgWe = 1'b0;
    memWrReady = 1'b1;
    #1;
    checkOutput("cfg_latched_gnt", gnt, 4'b0010);
    req = 4'h0;
    stepCycle();
    applyStimulus(4'b0010, 16'h00A0, 16'h00A0);
    stepCycle();
    checkOutput("cfg_now_denied", deny, 4'b0010);
    req = 4'h0;
    stepCycle();
    cfgWe = 1'b1;
    cfgPerm = 16'hFFFF;
    stepCycle();
    cfgWe = 1'b0;
    applyStimulus(4'b1000, 16'hA000, 16'h5000);
    stepCycle();
    checkOutput("cfg_open_gnt", gnt, 4'b1000);
    req = 4'h0;
    stepCycle();

    // Lockout after three denials, silent waiting, then lock_clr.
    doReset();
    for (int n = 0; n < 3; n++) denyId3($sformatf("t6_deny_%0d", n));
    checkOutput("t6_locked", locked, 4'b1000);
    checkOutput("t6_count3", violCount, 8'd3);
    applyStimulus(4'b1000, 16'hA000, 16'h5000);
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      checkOutput($sformatf("t6_silent_%0d", c), {memWrValid, violation, deny}, 6'h0);
    end
    lockClr = 1'b1;
    stepCycle();
    lockClr = 1'b0;
    checkOutput("t6_clr_locked", locked, 4'h0);
    checkOutput("t6_clr_no_deny", deny, 4'h0);
    stepCycle();
    checkOutput("t6_4th_deny", deny, 4'b1000);
    checkOutput("t6_count4", violCount, 8'd4);
    req = 4'h0;
    stepCycle();

    // lock_clr coinciding with the third denial wins: ID3 stays unlocked.
    denyId3("clr_race_pre");
    applyStimulus(4'b1000, 16'hA000, 16'h5000);
    lockClr = 1'b1;
    stepCycle();
    lockClr = 1'b0;
    checkOutput("clr_race_deny", deny, 4'b1000);
    checkOutput("clr_race_locked", locked, 4'h0);
    checkOutput("clr_race_count", violCount, 8'd6);
    req = 4'h0;
    stepCycle();
    denyId3("clr_race_post0");
    denyId3("clr_race_post1");
    checkOutput("clr_race_still_unlocked", locked, 4'h0);
    checkOutput("clr_race_count8", violCount, 8'd8);

    // Reset while in ISSUE drops valid without a grant.
    doReset();
    memWrReady = 1'b0;
    applyStimulus(4'b0010, 16'h00A0, 16'h00A0);
    stepCycle();
    checkOutput("rst_issue_valid_before", memWrValid, 1'b1);
    rst = 1'b1;
    stepCycle();
    checkOutput("rst_issue_valid", memWrValid, 1'b0);
    checkOutput("rst_issue_gnt", gnt, 4'h0);
    rst = 1'b0;
    memWrReady = 1'b1;
    req = 4'h0;
    stepCycle();
    checkOutput("rst_issue_after_gnt", gnt, 4'h0);

    // viol_count saturates at 255; lock_clr held so ID3 never locks.
    doReset();
    lockClr = 1'b1;
    applyStimulus(4'b1000, 16'hA000, 16'h5000);
    repeat (508) stepCycle();
    checkOutput("sat_254", violCount, 8'd254);
    repeat (12) stepCycle();
    checkOutput("sat_255", violCount, 8'd255);
    checkOutput("sat_locked", locked, 4'h0);
    lockClr = 1'b0;
    req = 4'h0;
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
